// File: rtl/vga_pattern_generator_if.sv
// Pixel-side bundle for the VGA pattern generator: upstream sync/blank strobes,
// async switch/mode inputs and the DAC-facing outputs.
interface vga_pattern_generator_if;
  logic       i_hsync_n;
  logic       i_vsync_n;
  logic       i_hblank_n;
  logic       i_vblank_n;
  logic [7:0] i_sw;
  logic [1:0] i_mode;
  logic [3:0] o_vga_r;
  logic [3:0] o_vga_g;
  logic [3:0] o_vga_b;
  logic       o_hsync_n;
  logic       o_vsync_n;
  logic [9:0] o_x;
  logic [9:0] o_y;
  logic       o_frame_start;

  modport master (
    output i_hsync_n, i_vsync_n, i_hblank_n, i_vblank_n, i_sw, i_mode,
    input  o_vga_r, o_vga_g, o_vga_b, o_hsync_n, o_vsync_n, o_x, o_y, o_frame_start
  );

  modport slave (
    input  i_hsync_n, i_vsync_n, i_hblank_n, i_vblank_n, i_sw, i_mode,
    output o_vga_r, o_vga_g, o_vga_b, o_hsync_n, o_vsync_n, o_x, o_y, o_frame_start
  );
endinterface

// File: rtl/vga_pattern_generator.sv
// Test-pattern colour source: tracks pixel position from blank strobes, renders one
// of four frame-latched patterns and delays syncs 2 clocks to stay aligned with RGB.
module vga_pattern_generator #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BAR_WIDTH = 80,
  parameter int THIRD     = 213
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  vga_pattern_generator_if.slave  vga
);

  localparam logic [9:0] XMAX = 10'(H_ACTIVE - 1);
  localparam logic [9:0] YMAX = 10'(V_ACTIVE - 1);
  localparam logic [9:0] T1   = 10'(THIRD);
  localparam logic [9:0] T2   = 10'(2 * THIRD);
  localparam logic [9:0] BW   = 10'(BAR_WIDTH);
  localparam logic [9:0] CMAX = 10'd1023;

  logic [7:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d, sw_f_q, sw_f_d;
  logic [1:0] mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d, mode_f_q, mode_f_d;
  logic       fs_q, fs_d;
  logic       a_d1_q, a_d1_d;
  logic       hs_d1_q, hs_d1_d, vs_d1_q, vs_d1_d;
  logic       hs_d2_q, hs_d2_d, vs_d2_q, vs_d2_d;
  logic [9:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [9:0] x_d1_q, x_d1_d, y_d1_q, y_d1_d;
  logic [9:0] ox_q, ox_d, oy_q, oy_d;
  logic [3:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic       active, vs_trig;
  logic [9:0] px, py, bar_idx;
  logic [2:0] bar_on;
  logic [3:0] lo, hi, pat_r, pat_g, pat_b;

  // Pattern math works on position clamped to the visible raster.
  always_comb begin
    px      = (x_d1_q > XMAX) ? XMAX : x_d1_q;
    py      = (y_d1_q > YMAX) ? YMAX : y_d1_q;
    lo      = sw_f_q[3:0];
    hi      = sw_f_q[7:4];
    bar_idx = px / BW;
    if (bar_idx > 10'd7) bar_idx = 10'd7;
    unique case (bar_idx[2:0])
      3'd0:    bar_on = 3'b111;
      3'd1:    bar_on = 3'b110;
      3'd2:    bar_on = 3'b011;
      3'd3:    bar_on = 3'b010;
      3'd4:    bar_on = 3'b101;
      3'd5:    bar_on = 3'b100;
      3'd6:    bar_on = 3'b001;
      default: bar_on = 3'b000;
    endcase
    pat_r = 4'h0;
    pat_g = 4'h0;
    pat_b = 4'h0;
    unique case (mode_f_q)
      2'd0: begin
        if (px < T1) begin
          pat_r = lo; pat_g = hi;
        end else if (px < T2) begin
          pat_g = lo; pat_b = hi;
        end else begin
          pat_r = hi; pat_b = lo;
        end
      end
      2'd1: begin
        pat_r = bar_on[2] ? lo : 4'h0;
        pat_g = bar_on[1] ? lo : 4'h0;
        pat_b = bar_on[0] ? lo : 4'h0;
      end
      2'd2: begin
        if (px[5] ^ py[5]) begin
          pat_r = lo; pat_g = hi; pat_b = lo;
        end
      end
      default: begin
        pat_r = px[9:6];
        pat_g = py[8:5];
        pat_b = lo;
      end
    endcase
  end

  always_comb begin
    active    = vga.i_hblank_n & vga.i_vblank_n;
    // Falling vsync seen against its own stage-1 copy.
    vs_trig   = ~vga.i_vsync_n & vs_d1_q;
    sw_s1_d   = vga.i_sw;
    sw_s2_d   = sw_s1_q;
    mode_s1_d = vga.i_mode;
    mode_s2_d = mode_s1_q;
    sw_f_d    = vs_trig ? sw_s2_q : sw_f_q;
    mode_f_d  = vs_trig ? mode_s2_q : mode_f_q;
    fs_d      = vs_trig;
    a_d1_d    = active;
    hs_d1_d   = vga.i_hsync_n;
    vs_d1_d   = vga.i_vsync_n;
    x_d1_d    = x_cnt_q;
    y_d1_d    = y_cnt_q;
    x_cnt_d   = active ? ((x_cnt_q == CMAX) ? CMAX : x_cnt_q + 10'd1) : 10'd0;
    y_cnt_d   = y_cnt_q;
    if (!vga.i_vblank_n)
      y_cnt_d = 10'd0;
    else if (a_d1_q && !active && y_cnt_q != CMAX)
      y_cnt_d = y_cnt_q + 10'd1;
    hs_d2_d   = hs_d1_q;
    vs_d2_d   = vs_d1_q;
    ox_d      = x_d1_q;
    oy_d      = y_d1_q;
    r_d       = a_d1_q ? pat_r : 4'h0;
    g_d       = a_d1_q ? pat_g : 4'h0;
    b_d       = a_d1_q ? pat_b : 4'h0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      sw_f_q    <= '0;
      mode_s1_q <= '0;
      mode_s2_q <= '0;
      mode_f_q  <= '0;
      fs_q      <= 1'b0;
      a_d1_q    <= 1'b0;
      hs_d1_q   <= 1'b1;
      vs_d1_q   <= 1'b1;
      hs_d2_q   <= 1'b1;
      vs_d2_q   <= 1'b1;
      x_cnt_q   <= '0;
      y_cnt_q   <= '0;
      x_d1_q    <= '0;
      y_d1_q    <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      sw_s1_q   <= sw_s1_d;
      sw_s2_q   <= sw_s2_d;
      sw_f_q    <= sw_f_d;
      mode_s1_q <= mode_s1_d;
      mode_s2_q <= mode_s2_d;
      mode_f_q  <= mode_f_d;
      fs_q      <= fs_d;
      a_d1_q    <= a_d1_d;
      hs_d1_q   <= hs_d1_d;
      vs_d1_q   <= vs_d1_d;
      hs_d2_q   <= hs_d2_d;
      vs_d2_q   <= vs_d2_d;
      x_cnt_q   <= x_cnt_d;
      y_cnt_q   <= y_cnt_d;
      x_d1_q    <= x_d1_d;
      y_d1_q    <= y_d1_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign vga.o_vga_r       = r_q;
  assign vga.o_vga_g       = g_q;
  assign vga.o_vga_b       = b_q;
  assign vga.o_hsync_n     = hs_d2_q;
  assign vga.o_vsync_n     = vs_d2_q;
  assign vga.o_x           = ox_q;
  assign vga.o_y           = oy_q;
  assign vga.o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_pattern_generator.sv
// Directed bench for vga_pattern_generator: short synthetic lines/frames, outputs
// sampled 1ns after each edge into per-cycle arrays, then checked against hand values.
module tb_vga_pattern_generator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  vga_pattern_generator_if vif();
  vga_pattern_generator dut (.i_clk(clk), .i_rst_n(rst_n), .vga(vif));

  int checks = 0;
  int errors = 0;
  int ns = 0;
  logic [11:0] s_rgb [0:2047];
  logic [9:0]  s_x   [0:2047];
  logic [9:0]  s_y   [0:2047];
  logic        s_hs  [0:2047];
  logic        s_vs  [0:2047];
  logic        s_fs  [0:2047];

  // Drive one cycle of sync/blank, then record outputs after the edge.
  task automatic step(input logic hs, input logic vs, input logic hb, input logic vb);
    vif.i_hsync_n = hs; vif.i_vsync_n = vs; vif.i_hblank_n = hb; vif.i_vblank_n = vb;
    @(posedge clk); #1;
    if (ns < 2048) begin
      s_rgb[ns] = {vif.o_vga_r, vif.o_vga_g, vif.o_vga_b};
      s_x[ns] = vif.o_x; s_y[ns] = vif.o_y;
      s_hs[ns] = vif.o_hsync_n; s_vs[ns] = vif.o_vsync_n; s_fs[ns] = vif.o_frame_start;
      ns++;
    end
  endtask

  // n active pixels then a 7-cycle hblank with a 3-cycle hsync pulse at offset 2.
  task automatic line(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 1, 1);
    step(1, 1, 0, 1); step(1, 1, 0, 1);
    repeat (3) step(0, 1, 0, 1);
    step(1, 1, 0, 1); step(1, 1, 0, 1);
  endtask

  // Vertical blank with vsync falling on step 3 and rising on step 6.
  task automatic vframe();
    repeat (3) step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({vif.o_vga_r, vif.o_vga_g, vif.o_vga_b} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", {vif.o_vga_r, vif.o_vga_g, vif.o_vga_b}); end
    checks++; if ({vif.o_hsync_n, vif.o_vsync_n} !== 2'b11) begin errors++; $display("FAIL reset_syncs got %b exp 11", {vif.o_hsync_n, vif.o_vsync_n}); end
    checks++; if ({vif.o_x, vif.o_y} !== 20'h0) begin errors++; $display("FAIL reset_xy got %0d,%0d exp 0,0", vif.o_x, vif.o_y); end
    checks++; if (vif.o_frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", vif.o_frame_start); end
    rst_n = 1'b1;
    ns = 0;
    repeat (4) step(1, 1, 0, 0);
    checks++; if (s_rgb[3] !== 12'h000) begin errors++; $display("FAIL idle_rgb got %h exp 000", s_rgb[3]); end
    checks++; if ({s_hs[3], s_vs[3]} !== 2'b11) begin errors++; $display("FAIL idle_syncs got %b exp 11", {s_hs[3], s_vs[3]}); end
    checks++; if ({s_x[3], s_y[3]} !== 20'h0) begin errors++; $display("FAIL idle_xy got %0d,%0d exp 0,0", s_x[3], s_y[3]); end
  endtask

  task automatic test_thirds();
    int c;
    vif.i_sw = 8'hA5; vif.i_mode = 2'd0;
    ns = 0; vframe();
    checks++; if ({s_vs[3], s_vs[4], s_vs[7]} !== 3'b101) begin errors++; $display("FAIL vsync_latency got %b exp 101", {s_vs[3], s_vs[4], s_vs[7]}); end
    c = 0; for (int i = 0; i < ns; i++) if (s_fs[i] === 1'b1) c++;
    checks++; if (c !== 1) begin errors++; $display("FAIL thirds_fs_count got %0d exp 1", c); end
    ns = 0; line(640);
    checks++; if (s_rgb[0] !== 12'h000) begin errors++; $display("FAIL thirds_pre got %h exp 000", s_rgb[0]); end
    checks++; if (s_rgb[1] !== 12'h5A0 || s_x[1] !== 10'd0) begin errors++; $display("FAIL thirds_p0 got %h x=%0d exp 5a0 x=0", s_rgb[1], s_x[1]); end
    checks++; if (s_rgb[213] !== 12'h5A0) begin errors++; $display("FAIL thirds_p212 got %h exp 5a0", s_rgb[213]); end
    checks++; if (s_rgb[214] !== 12'h05A || s_x[214] !== 10'd213) begin errors++; $display("FAIL thirds_p213 got %h x=%0d exp 05a x=213", s_rgb[214], s_x[214]); end
    checks++; if (s_rgb[426] !== 12'h05A) begin errors++; $display("FAIL thirds_p425 got %h exp 05a", s_rgb[426]); end
    checks++; if (s_rgb[427] !== 12'hA05) begin errors++; $display("FAIL thirds_p426 got %h exp a05", s_rgb[427]); end
    checks++; if (s_rgb[640] !== 12'hA05 || s_x[640] !== 10'd639) begin errors++; $display("FAIL thirds_p639 got %h x=%0d exp a05 x=639", s_rgb[640], s_x[640]); end
    checks++; if (s_rgb[641] !== 12'h000) begin errors++; $display("FAIL thirds_after got %h exp 000", s_rgb[641]); end
    checks++; if ({s_hs[642], s_hs[643]} !== 2'b10) begin errors++; $display("FAIL hsync_latency got %b exp 10", {s_hs[642], s_hs[643]}); end
  endtask

  task automatic test_frame_latch();
    int c;
    logic [11:0] acc;
    vif.i_sw = 8'h00; vif.i_mode = 2'd0;
    ns = 0; vframe();
    ns = 0; line(100);
    vif.i_sw = 8'hFF;
    ns = 0; line(640);
    acc = 12'h000; c = 0;
    for (int i = 0; i < ns; i++) begin acc = acc | s_rgb[i]; if (s_fs[i] === 1'b1) c++; end
    checks++; if (acc !== 12'h000) begin errors++; $display("FAIL latch_midframe_rgb got %h exp 000", acc); end
    checks++; if (c !== 0) begin errors++; $display("FAIL latch_midframe_fs got %0d exp 0", c); end
    ns = 0; vframe();
    c = 0; for (int i = 0; i < ns; i++) if (s_fs[i] === 1'b1) c++;
    checks++; if (c !== 1) begin errors++; $display("FAIL latch_fs_count got %0d exp 1", c); end
    ns = 0; line(640);
    checks++; if (s_rgb[1] !== 12'hFF0) begin errors++; $display("FAIL latch_p0 got %h exp ff0", s_rgb[1]); end
    checks++; if (s_rgb[214] !== 12'h0FF) begin errors++; $display("FAIL latch_p213 got %h exp 0ff", s_rgb[214]); end
    checks++; if (s_rgb[640] !== 12'hF0F) begin errors++; $display("FAIL latch_p639 got %h exp f0f", s_rgb[640]); end
  endtask

  task automatic test_bars();
    int          bx [13] = '{0, 79, 80, 159, 160, 239, 240, 320, 400, 480, 559, 560, 639};
    logic [11:0] be [13] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'hFF0, 12'h0FF, 12'h0FF, 12'h0F0,
                             12'hF0F, 12'hF00, 12'h00F, 12'h00F, 12'h000, 12'h000};
    vif.i_sw = 8'h0F; vif.i_mode = 2'd1;
    ns = 0; vframe();
    ns = 0; line(640);
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (s_rgb[bx[i]+1] !== be[i] || s_x[bx[i]+1] !== 10'(bx[i])) begin
        errors++;
        $display("FAIL bars_x%0d got %h x=%0d exp %h x=%0d", bx[i], s_rgb[bx[i]+1], s_x[bx[i]+1], be[i], bx[i]);
      end
    end
  endtask

  task automatic test_checker_gradient();
    vif.i_sw = 8'h0F; vif.i_mode = 2'd2;
    ns = 0; vframe();
    ns = 0; line(64);
    checks++; if (s_rgb[33] !== 12'hF0F || s_y[33] !== 10'd0) begin errors++; $display("FAIL checker_32_0 got %h y=%0d exp f0f y=0", s_rgb[33], s_y[33]); end
    checks++; if (s_rgb[1] !== 12'h000) begin errors++; $display("FAIL checker_0_0 got %h exp 000", s_rgb[1]); end
    ns = 0; line(1);
    checks++; if (s_y[1] !== 10'd1) begin errors++; $display("FAIL y_row1 got %0d exp 1", s_y[1]); end
    ns = 0; line(1);
    checks++; if (s_y[1] !== 10'd2) begin errors++; $display("FAIL y_row2 got %0d exp 2", s_y[1]); end
    for (int r = 3; r < 32; r++) begin ns = 0; line(1); end
    ns = 0; line(64);
    checks++; if (s_rgb[33] !== 12'h000 || s_y[33] !== 10'd32) begin errors++; $display("FAIL checker_32_32 got %h y=%0d exp 000 y=32", s_rgb[33], s_y[33]); end
    checks++; if (s_rgb[1] !== 12'hF0F) begin errors++; $display("FAIL checker_0_32 got %h exp f0f", s_rgb[1]); end
    vif.i_mode = 2'd3;
    ns = 0; vframe();
    ns = 0; line(8);
    checks++; if (s_y[1] !== 10'd0 || s_rgb[1] !== 12'h00F) begin errors++; $display("FAIL grad_0_0 got %h y=%0d exp 00f y=0", s_rgb[1], s_y[1]); end
    for (int r = 1; r < 479; r++) begin ns = 0; line(1); end
    ns = 0; line(640);
    checks++; if (s_rgb[640] !== 12'h9EF || s_y[640] !== 10'd479) begin errors++; $display("FAIL grad_639_479 got %h y=%0d exp 9ef y=479", s_rgb[640], s_y[640]); end
    checks++; if (s_rgb[65] !== 12'h1EF) begin errors++; $display("FAIL grad_64_479 got %h exp 1ef", s_rgb[65]); end
  endtask

  task automatic test_x_saturate();
    ns = 0; line(1100);
    checks++; if (s_x[1023] !== 10'd1022) begin errors++; $display("FAIL xsat_1022 got %0d exp 1022", s_x[1023]); end
    checks++; if (s_x[1024] !== 10'd1023) begin errors++; $display("FAIL xsat_1023 got %0d exp 1023", s_x[1024]); end
    checks++; if (s_x[1051] !== 10'd1023) begin errors++; $display("FAIL xsat_hold got %0d exp 1023", s_x[1051]); end
  endtask

  task automatic test_reset_midline();
    vif.i_sw = 8'h0F; vif.i_mode = 2'd3;
    ns = 0; vframe();
    ns = 0;
    for (int i = 0; i < 50; i++) step(1, 1, 1, 1);
    checks++; if (s_rgb[49] !== 12'h00F) begin errors++; $display("FAIL midline_pre got %h exp 00f", s_rgb[49]); end
    #5 rst_n = 1'b0;
    #1;
    checks++; if ({vif.o_vga_r, vif.o_vga_g, vif.o_vga_b} !== 12'h000 || vif.o_x !== 10'd0) begin errors++; $display("FAIL midline_async got %h x=%0d exp 000 x=0", {vif.o_vga_r, vif.o_vga_g, vif.o_vga_b}, vif.o_x); end
    checks++; if ({vif.o_hsync_n, vif.o_vsync_n} !== 2'b11) begin errors++; $display("FAIL midline_syncs got %b exp 11", {vif.o_hsync_n, vif.o_vsync_n}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ns = 0; repeat (3) step(1, 1, 0, 1);
    ns = 0; line(200);
    checks++; if (s_rgb[101] !== 12'h000) begin errors++; $display("FAIL post_reset_mode got %h exp 000", s_rgb[101]); end
    ns = 0; vframe();
    ns = 0; line(200);
    checks++; if (s_rgb[101] !== 12'h10F) begin errors++; $display("FAIL post_vsync_mode got %h exp 10f", s_rgb[101]); end
  endtask

  initial begin
    vif.i_hsync_n = 1'b1; vif.i_vsync_n = 1'b1;
    vif.i_hblank_n = 1'b0; vif.i_vblank_n = 1'b0;
    vif.i_sw = 8'h00; vif.i_mode = 2'd0;
    test_reset();
    test_thirds();
    test_frame_latch();
    test_bars();
    test_checker_gradient();
    test_x_saturate();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
